wm_seq: RTL and testbench
=========================

WM_SEQ -- requirements
Module: wm_seq

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter MS_PER_SEC, 1000, number of clkCnt_1msEnd ticks per second.
REQ-002 The block SHALL have parameters FILL_SEC 10, WASH_SEC 60, RINSE_SEC 30, SPIN_SEC 20, DONE_SEC 5, giving phase durations in seconds; each is at least 1.
REQ-003 The block SHALL have parameter QUICK_DIV, 2, the divisor applied to WASH_SEC and RINSE_SEC in quick mode (integer division, minimum result 1).

Ports (name  direction  width  meaning):
REQ-004 The block SHALL have port clk  in  1  system clock; the block uses this one clock only.
REQ-005 The block SHALL have port rstn  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port clkCnt_1msEnd  in  1  one-cycle 1 ms tick.
REQ-007 The block SHALL have ports start_en, stop_en, mode_en  in  1 each  one-cycle debounced button pulses.
REQ-008 The block SHALL have port mode  out  2  selected program: 0 standard, 1 quick, 2 spin-only.
REQ-009 The block SHALL have port state  out  3  encoded as IDLE 0, FILL 1, WASH 2, RINSE 3, SPIN 4, DONE 5, PAUSE 6.
REQ-010 The block SHALL have ports water_in, motor_on, motor_fast, drain  out  1 each  actuator enables.
REQ-011 The block SHALL have port remain_sec  out  8  seconds left in the current phase.
REQ-012 The block SHALL have port done  out  1  high while in DONE.

Function
REQ-013 An ms counter SHALL count clkCnt_1msEnd ticks from 0 to MS_PER_SEC-1 and wrap; sec_tick SHALL be tick AND (count == MS_PER_SEC-1).
REQ-014 The ms counter SHALL run only in FILL, WASH, RINSE, SPIN and DONE; it SHALL hold in PAUSE and clear to 0 in IDLE and on every phase entry.
REQ-015 On phase entry, remain_sec SHALL load that phase's duration; on each sec_tick it SHALL decrement.
REQ-016 When sec_tick occurs with remain_sec == 1, the block SHALL take the next transition in that same clock edge.
REQ-017 The transition order SHALL be: standard and quick run FILL -> WASH -> RINSE -> SPIN -> DONE -> IDLE; spin-only runs SPIN -> DONE -> IDLE.
REQ-018 In IDLE, each mode_en SHALL advance mode 0 -> 1 -> 2 -> 0; mode_en SHALL be ignored in all other states.
REQ-019 In IDLE, start_en SHALL enter FILL, or SPIN when mode == 2; remain_sec SHALL read 0 in IDLE.
REQ-020 In FILL, WASH, RINSE or SPIN, start_en SHALL enter PAUSE and save the interrupted state; in PAUSE, start_en SHALL return to the saved state with remain_sec and the ms counter unchanged.
REQ-021 stop_en in any state other than IDLE SHALL go to IDLE next cycle; mode SHALL be kept.
REQ-022 Priority for same-cycle pulses SHALL be stop_en, then start_en, then mode_en, then timer expiry; the lower-priority events SHALL be discarded.
REQ-023 In DONE, start_en SHALL return to IDLE immediately.
REQ-024 Outputs SHALL be registered and decoded from the next state, giving zero-cycle lag after a state change:
- FILL: water_in.
- WASH: motor_on.
- RINSE: water_in and motor_on.
- SPIN: motor_on, motor_fast and drain.
- DONE: done.
- All other states: all actuator outputs 0.
REQ-025 All counters SHALL be sized to their parameters with no overflow; remain_sec SHALL never underflow below 0.

Reset
REQ-026 While rstn = 0, the block SHALL force asynchronously:
- state IDLE, mode 0, remain_sec 0, ms counter 0, saved state IDLE.
- All outputs 0.
REQ-027 Reset asserted mid-cycle of any phase SHALL abort the program with no residual actuator output.

Verification
REQ-028 Use MS_PER_SEC 4, FILL_SEC 2, WASH_SEC 3, RINSE_SEC 2, SPIN_SEC 2, DONE_SEC 1. With tick every cycle and mode 0, start_en -> FILL 8 cycles, WASH 12, RINSE 8, SPIN 8, DONE 4, then IDLE; outputs match REQ-024 in every phase.
REQ-029 Apply mode_en x2, then start_en -> mode = 2, SPIN entered directly, remain_sec = 2; then DONE, then IDLE.
REQ-030 Apply start_en at WASH remain_sec = 2 -> PAUSE, outputs 0, counters frozen for 20 cycles; then start_en -> WASH resumes with remain_sec 2 and the same ms count.
REQ-031 Pulse stop_en and start_en in the same cycle during RINSE -> IDLE next cycle, all outputs 0, mode unchanged.
REQ-032 Pulse mode_en during WASH -> mode unchanged; with mode 1 (quick), WASH lasts 1 s and RINSE lasts 1 s.
REQ-033 Assert rstn low during SPIN -> all outputs 0 immediately; after release, state is IDLE and mode is 0.

Source files
------------

// File: rtl/wm_seq_if.sv
// wm_seq_if: tick and button inputs plus status and actuator outputs of the wash sequencer.
interface wm_seq_if;
    logic       clkCnt_1msEnd;
    logic       start_en;
    logic       stop_en;
    logic       mode_en;
    logic [1:0] mode;
    logic [2:0] state;
    logic       water_in;
    logic       motor_on;
    logic       motor_fast;
    logic       drain;
    logic [7:0] remain_sec;
    logic       done;

    modport master (
        output clkCnt_1msEnd, start_en, stop_en, mode_en,
        input  mode, state, water_in, motor_on, motor_fast, drain, remain_sec, done
    );

    modport slave (
        input  clkCnt_1msEnd, start_en, stop_en, mode_en,
        output mode, state, water_in, motor_on, motor_fast, drain, remain_sec, done
    );
endinterface

// File: rtl/wm_seq.sv
// wm_seq: washing-machine program sequencer with timed phases, pause/resume, stop and mode select.
module wm_seq #(
    parameter int MS_PER_SEC = 1000,
    parameter int FILL_SEC   = 10,
    parameter int WASH_SEC   = 60,
    parameter int RINSE_SEC  = 30,
    parameter int SPIN_SEC   = 20,
    parameter int DONE_SEC   = 5,
    parameter int QUICK_DIV  = 2
) (
    input logic     clk,
    input logic     rstn,
    wm_seq_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_WASH  = 3'd2;
    localparam logic [2:0] S_RINSE = 3'd3;
    localparam logic [2:0] S_SPIN  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_PAUSE = 3'd6;
    localparam int MSW = MS_PER_SEC > 1 ? $clog2(MS_PER_SEC) : 1;
    localparam logic [MSW-1:0] MS_LAST = MSW'(MS_PER_SEC - 1);
    localparam int QW = (WASH_SEC / QUICK_DIV) > 1 ? WASH_SEC / QUICK_DIV : 1;
    localparam int QR = (RINSE_SEC / QUICK_DIV) > 1 ? RINSE_SEC / QUICK_DIV : 1;

    logic [2:0]     state_q, state_d, saved_q, saved_d, tgt;
    logic [1:0]     mode_q, mode_d;
    logic [7:0]     remain_q, remain_d;
    logic [MSW-1:0] ms_q, ms_d;
    logic           running, sec_tick, load;

    // Idle loads 0 so remain_sec reads 0 whenever the machine is idle.
    function automatic logic [7:0] dur(input logic [2:0] s, input logic quick);
        return s == S_FILL  ? 8'(FILL_SEC) :
               s == S_WASH  ? (quick ? 8'(QW) : 8'(WASH_SEC)) :
               s == S_RINSE ? (quick ? 8'(QR) : 8'(RINSE_SEC)) :
               s == S_SPIN  ? 8'(SPIN_SEC) :
               s == S_DONE  ? 8'(DONE_SEC) : 8'd0;
    endfunction

    assign running  = state_q >= S_FILL && state_q <= S_DONE;
    assign sec_tick = running && bus.clkCnt_1msEnd && ms_q == MS_LAST;

    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        mode_d   = mode_q;
        remain_d = remain_q;
        ms_d     = ms_q;
        load     = 1'b0;
        tgt      = state_q;
        if (bus.stop_en) begin
            load = state_q != S_IDLE;
            tgt  = S_IDLE;
        end else if (bus.start_en) begin
            if (state_q == S_IDLE || state_q == S_DONE) begin
                load = 1'b1;
                tgt  = state_q == S_DONE ? S_IDLE : mode_q == 2'd2 ? S_SPIN : S_FILL;
            end else if (state_q == S_PAUSE) begin
                state_d = saved_q;
            end else begin
                state_d = S_PAUSE;
                saved_d = state_q;
            end
        end else if (bus.mode_en && state_q == S_IDLE) begin
            mode_d = mode_q == 2'd2 ? 2'd0 : mode_q + 2'd1;
        end else if (sec_tick && remain_q <= 8'd1) begin
            load = 1'b1;
            tgt  = state_q == S_DONE ? S_IDLE : state_q + 3'd1;
        end else if (sec_tick) begin
            remain_d = remain_q - 8'd1;
            ms_d     = '0;
        end else if (running && bus.clkCnt_1msEnd) begin
            ms_d = ms_q + 1'b1;
        end
        if (load) begin
            state_d  = tgt;
            remain_d = dur(tgt, mode_q == 2'd1);
            ms_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            saved_q  <= S_IDLE;
            mode_q   <= 2'd0;
            remain_q <= 8'd0;
            ms_q     <= '0;
        end else begin
            state_q  <= state_d;
            saved_q  <= saved_d;
            mode_q   <= mode_d;
            remain_q <= remain_d;
            ms_q     <= ms_d;
        end
    end

    // Actuators decode the next state so they switch on the same edge as state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.water_in   <= 1'b0;
            bus.motor_on   <= 1'b0;
            bus.motor_fast <= 1'b0;
            bus.drain      <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            bus.water_in   <= state_d == S_FILL || state_d == S_RINSE;
            bus.motor_on   <= state_d == S_WASH || state_d == S_RINSE || state_d == S_SPIN;
            bus.motor_fast <= state_d == S_SPIN;
            bus.drain      <= state_d == S_SPIN;
            bus.done       <= state_d == S_DONE;
        end
    end

    assign bus.state      = state_q;
    assign bus.mode       = mode_q;
    assign bus.remain_sec = remain_q;
endmodule

// File: tb/tb_wm_seq.sv
// tb_wm_seq: directed scenarios plus random button traffic against a program-list reference model.
module tb_wm_seq;
    localparam int MS = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cnt [7];

    wm_seq_if bus ();

    wm_seq #(
        .MS_PER_SEC(MS), .FILL_SEC(2), .WASH_SEC(3), .RINSE_SEC(2),
        .SPIN_SEC(2), .DONE_SEC(1), .QUICK_DIV(2)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: a program is a list of phases; time left is counted in raw ms ticks.
    int prog_std  [5] = '{1, 2, 3, 4, 5};
    int prog_spin [2] = '{4, 5};
    bit m_active, m_paused;
    int m_mode, m_prog, m_pos, m_left;

    function automatic int phase_at(int p, int pos);
        return p == 2 ? prog_spin[pos] : prog_std[pos];
    endfunction

    function automatic int plen(int p);
        return p == 2 ? 2 : 5;
    endfunction

    function automatic int pdur(int ph, int md);
        case (ph)
            1: return 2;
            2: return md == 1 ? 1 : 3;
            3: return md == 1 ? 1 : 2;
            4: return 2;
            5: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int acts(int s);
        case (s)
            1: return 'b10000;
            2: return 'b01000;
            3: return 'b11000;
            4: return 'b01110;
            5: return 'b00001;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_state();
        return !m_active ? 0 : m_paused ? 6 : phase_at(m_prog, m_pos);
    endfunction

    function automatic int exp_remain();
        return m_active ? (m_left + MS - 1) / MS : 0;
    endfunction

    function automatic void model_reset();
        m_active = 0;
        m_paused = 0;
        m_mode   = 0;
        m_prog   = 0;
        m_pos    = 0;
        m_left   = 0;
    endfunction

    function automatic void model_step(bit tk, bit st, bit sp, bit md);
        if (sp) begin
            m_active = 0;
            m_paused = 0;
        end else if (st) begin
            if (!m_active) begin
                m_prog   = m_mode;
                m_pos    = 0;
                m_active = 1;
                m_left   = pdur(phase_at(m_prog, 0), m_mode) * MS;
            end else if (m_paused) m_paused = 0;
            else if (phase_at(m_prog, m_pos) == 5) m_active = 0;
            else m_paused = 1;
        end else if (md && !m_active) begin
            m_mode = (m_mode + 1) % 3;
        end else if (tk && m_active && !m_paused) begin
            m_left--;
            if (m_left == 0) begin
                m_pos++;
                if (m_pos == plen(m_prog)) m_active = 0;
                else m_left = pdur(phase_at(m_prog, m_pos), m_mode) * MS;
            end
        end
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic int outs();
        return int'({bus.water_in, bus.motor_on, bus.motor_fast, bus.drain, bus.done});
    endfunction

    task automatic compare();
        check("state", int'(bus.state), exp_state());
        check("mode", int'(bus.mode), m_mode);
        check("remain", int'(bus.remain_sec), exp_remain());
        check("acts", outs(), acts(exp_state()));
    endtask

    task automatic cycle(input bit tk, input bit st, input bit sp, input bit md);
        bus.clkCnt_1msEnd = tk;
        bus.start_en      = st;
        bus.stop_en       = sp;
        bus.mode_en       = md;
        @(posedge clk);
        model_step(tk, st, sp, md);
        @(negedge clk);
        bus.start_en = 1'b0;
        bus.stop_en  = 1'b0;
        bus.mode_en  = 1'b0;
        compare();
    endtask

    task automatic wait_for(input int s, input int r);
        for (int n = 0; n < 200; n++) begin
            if (int'(bus.state) == s && (r < 0 || int'(bus.remain_sec) == r)) return;
            cycle(1, 0, 0, 0);
        end
        check("wait_timeout", int'(bus.state), s);
    endtask

    task automatic run_prog(input bit st, input bit md);
        foreach (cnt[i]) cnt[i] = 0;
        for (int n = 0; n < 200; n++) begin
            cycle(1, st && n == 0, 0, md && n == 0);
            if (bus.state == 3'd0) return;
            cnt[bus.state]++;
        end
        check("run_timeout", int'(bus.state), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.clkCnt_1msEnd = 1'b0;
        bus.start_en      = 1'b0;
        bus.stop_en       = 1'b0;
        bus.mode_en       = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_state", int'(bus.state), 0);
        check("rst_mode", int'(bus.mode), 0);
        check("rst_remain", int'(bus.remain_sec), 0);
        check("rst_acts", outs(), 0);
        rstn = 1'b1;
        @(negedge clk);
        // Standard program phase lengths with a tick every cycle.
        run_prog(1, 0);
        check("fill_cycles", cnt[1], 8);
        check("wash_cycles", cnt[2], 12);
        check("rinse_cycles", cnt[3], 8);
        check("spin_cycles", cnt[4], 8);
        check("done_cycles", cnt[5], 4);
        // Spin-only program.
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        check("mode_spin", int'(bus.mode), 2);
        cycle(1, 1, 0, 0);
        check("spin_entry", int'(bus.state), 4);
        check("spin_remain", int'(bus.remain_sec), 2);
        run_prog(0, 0);
        check("spin_only_fill", cnt[1], 0);
        check("spin_only_spin", cnt[4], 7);
        check("spin_only_done", cnt[5], 4);
        // Pause in WASH with a part-elapsed second, then resume.
        cycle(1, 0, 0, 1);
        cycle(1, 1, 0, 0);
        wait_for(2, 2);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        check("pause_state", int'(bus.state), 6);
        check("pause_acts", outs(), 0);
        repeat (20) cycle(1, 0, 0, 0);
        check("pause_remain", int'(bus.remain_sec), 2);
        cycle(1, 1, 0, 0);
        check("resume_state", int'(bus.state), 2);
        check("resume_remain", int'(bus.remain_sec), 2);
        run_prog(0, 0);
        check("wash_after_resume", cnt[2] + 1, 6);
        // Stop and start together during RINSE.
        cycle(1, 1, 0, 0);
        wait_for(3, -1);
        cycle(1, 1, 1, 0);
        check("stop_state", int'(bus.state), 0);
        check("stop_acts", outs(), 0);
        check("stop_mode", int'(bus.mode), 0);
        // Quick mode, with a mode press during WASH.
        cycle(1, 0, 0, 1);
        cycle(1, 1, 0, 0);
        wait_for(2, -1);
        run_prog(0, 1);
        check("quick_mode_kept", int'(bus.mode), 1);
        check("quick_wash", cnt[2] + 1, 4);
        check("quick_rinse", cnt[3], 4);
        // Asynchronous reset in the middle of SPIN.
        cycle(1, 1, 0, 0);
        wait_for(4, -1);
        cycle(1, 0, 0, 0);
        #2 rstn = 1'b0;
        #1;
        check("areset_acts", outs(), 0);
        check("areset_state", int'(bus.state), 0);
        check("areset_mode", int'(bus.mode), 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        cycle(1, 0, 0, 0);
        // Random button and tick traffic.
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            cycle($urandom_range(0, 2) != 0, r < 4, r >= 4 && r < 6, r >= 6 && r < 10);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
